// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx: I2S serializer with BCLK/LRCK/FSCLK generation and a one-pair holding register
module i2s_dac_tx #(
   parameter int MCLK_DIV = 4
) (
   input  logic        MCLK,
   input  logic        RST,
   input  logic [15:0] LDATA,
   input  logic [15:0] RDATA,
   input  logic        DIN_VALID,
   output logic        DIN_READY,
   output logic        BCLK,
   output logic        LRCK,
   output logic        SDATA,
   output logic        FSCLK,
   output logic        UNDERRUN
);
   localparam int DW = $clog2(MCLK_DIV);
   localparam logic [DW-1:0] DMAX = DW'(MCLK_DIV - 1);
   logic [DW-1:0] div_cnt;
   logic [4:0]    bit_cnt, bit_nxt;
   logic [31:0]   shifter, last_pair, hold, next_pair;
   logic          full, tick, fall, load, accept;
   always_comb begin
      tick      = div_cnt == DMAX;
      fall      = tick & BCLK;
      bit_nxt   = bit_cnt + 5'd1;
      load      = fall & (bit_cnt == 5'd31);
      accept    = DIN_VALID & ~full;
      next_pair = full ? hold : DIN_VALID ? {LDATA, RDATA} : last_pair;
   end
   assign DIN_READY = ~full;
   assign FSCLK     = LRCK;
   // SDATA shows shifter[31] one BCLK after each shift, giving the one-bit I2S delay
   always_ff @(posedge MCLK) begin
      if (RST) begin
         div_cnt   <= '0;
         bit_cnt   <= 5'd31;
         BCLK      <= 1'b0;
         LRCK      <= 1'b0;
         SDATA     <= 1'b0;
         UNDERRUN  <= 1'b0;
         shifter   <= '0;
         last_pair <= '0;
         hold      <= '0;
         full      <= 1'b0;
      end else begin
         div_cnt  <= tick ? '0 : div_cnt + 1'b1;
         BCLK     <= BCLK ^ tick;
         UNDERRUN <= load & ~full & ~DIN_VALID;
         if (fall) begin
            bit_cnt <= bit_nxt;
            LRCK    <= bit_nxt[4];
            SDATA   <= shifter[31];
            shifter <= load ? next_pair : {shifter[30:0], 1'b0};
         end
         if (load) begin
            last_pair <= next_pair;
            full      <= 1'b0;
         end else if (accept) begin
            hold <= {LDATA, RDATA};
            full <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_i2s_dac_tx.sv
// tb_i2s_dac_tx: randomized scoreboard bench for i2s_dac_tx at MCLK_DIV = 4 and 2
module tb_i2s_dac_tx;
   logic MCLK = 1'b0;
   always #5 MCLK = ~MCLK;
   int cmp = 0, err = 0;
   logic [1:0] done = 2'b00;
   task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
      cmp++;
      if (a !== e) begin
         err++;
         if (err <= 40) $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
      end
   endtask
   for (genvar g = 0; g < 2; g++) begin : u
      localparam int D = g ? 2 : 4;
      localparam int F = 64 * D;
      logic rst = 1'b1, vin = 1'b0, rdy, bclk, lrck, sd, fs, und;
      logic [15:0] l = '0, r = '0;
      i2s_dac_tx #(.MCLK_DIV(D)) dut (
         .MCLK(MCLK), .RST(rst), .LDATA(l), .RDATA(r), .DIN_VALID(vin), .DIN_READY(rdy),
         .BCLK(bclk), .LRCK(lrck), .SDATA(sd), .FSCLK(fs), .UNDERRUN(und)
      );
      int t = 0;
      logic m_full = 1'b0, m_und = 1'b0;
      logic [31:0] m_hold = '0, m_last = '0;
      logic [31:0] q[$];
      function automatic bit is_load(input int tt);
         return tt >= 2 * D && (tt - 2 * D) % F == 0;
      endfunction
      // Reference model: t counts edges since reset release; frames start every F edges from 2*D
      always @(posedge MCLK) begin
         if (rst) begin
            t = 0; m_full = 0; m_und = 0; m_hold = '0; m_last = '0; q.delete();
         end else begin
            t++;
            m_und = 0;
            if (is_load(t)) begin
               if (m_full) m_last = m_hold;
               else if (vin) m_last = {l, r};
               else m_und = 1;
               m_full = 0;
               q.push_back(m_last);
            end else if (vin && !m_full) begin
               m_hold = {l, r};
               m_full = 1;
            end
         end
      end
      logic pb = 1'b0, plr = 1'b0, psd = 1'b0, exp_bc, exp_lr;
      logic [31:0] acc = '0;
      always @(negedge MCLK) begin
         exp_bc = ((t / D) % 2) != 0;
         exp_lr = t >= 2 * D && ((t - 2 * D) % F) >= F / 2;
         check($sformatf("pins_div%0d", D), {27'd0, bclk, lrck, fs, und, rdy},
               {27'd0, exp_bc, exp_lr, exp_lr, m_und, !m_full});
         if (t < 4 * D) check($sformatf("sdata_idle_div%0d", D), {31'd0, sd}, 32'd0);
         if (t != 0 && !(pb && !bclk)) check($sformatf("sdata_edge_div%0d", D), {31'd0, sd}, {31'd0, psd});
         if (t == 0) plr = 1'b0;
         else if (bclk && !pb) begin
            acc = {acc[30:0], sd};
            if (!lrck && plr) begin
               if (q.size() == 0) check($sformatf("queue_empty_div%0d", D), 32'd1, 32'd0);
               else check($sformatf("frame_div%0d", D), acc, q.pop_front());
            end
            plr = lrck;
         end
         pb  = bclk;
         psd = sd;
      end
      logic [15:0] inc = 16'd0;
      task automatic run(input int m, input int frames);
         for (int c = 0; c < frames * F; c++) begin
            @(negedge MCLK);
            l = 16'($urandom);
            r = 16'($urandom);
            case (m)
               0: vin = $urandom_range(0, 3) == 0;
               1: begin vin = 1'b1; l = inc; r = inc + 16'd1; inc = inc + 16'd2; end
               2: vin = 1'b0;
               default: begin vin = is_load(t + 1); l = 16'h7FFF; r = 16'h8000; end
            endcase
         end
      endtask
      initial begin
         repeat (3) @(negedge MCLK);
         rst = 1'b0;
         vin = 1'b1; l = 16'hA5C3; r = 16'h3C5A;
         @(negedge MCLK);
         vin = 1'b0; l = 16'h1234; r = 16'h5678;
         repeat (F) @(negedge MCLK);
         vin = 1'b1;
         @(negedge MCLK);
         vin = 1'b0;
         run(2, 3);
         for (int p = 0; p < 8; p++) run(p % 4, 2);
         repeat ($urandom_range(F / 4, F / 2)) @(negedge MCLK);
         rst = 1'b1; vin = 1'b1;
         repeat (3) @(negedge MCLK);
         rst = 1'b0; vin = 1'b0;
         for (int p = 0; p < 4; p++) run(p, 2);
         run(2, 1);
         done[g] = 1'b1;
      end
   end
   initial begin
      fork
         wait (done == 2'b11);
         #900000;
      join_any
      if (done != 2'b11) check("timeout", {30'd0, done}, 32'd3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
      $finish;
   end
endmodule
